// File: rtl/rram_ctrl_pkg.sv
// Shared types and opcode constants for the RRAM controller path.
package rram_ctrl_pkg;
  localparam int INSTR_WIDTH  = 4;
  localparam int OPCODE_WIDTH = 16;
  localparam int WORD_WIDTH   = INSTR_WIDTH + OPCODE_WIDTH;

  typedef logic [WORD_WIDTH-1:0] inst_word_t;

  localparam logic [INSTR_WIDTH-1:0] STORE      = 4'h4;
  localparam logic [INSTR_WIDTH-1:0] READ       = 4'h5;
  localparam logic [INSTR_WIDTH-1:0] HAM_WEIGHT = 4'h6;
  localparam logic [INSTR_WIDTH-1:0] HAM_SEG    = 4'h7;

  // Opcode sits in the top bits of the instruction word.
  function automatic logic [INSTR_WIDTH-1:0] opcode_of(input inst_word_t w);
    return w[WORD_WIDTH-1 -: INSTR_WIDTH];
  endfunction
endpackage

// File: rtl/rram_fifo_ptr.sv
// Pointer, occupancy and flag logic for the instruction FIFO.
// Flags depend only on registered pointers; accept strobes are combinational.
module rram_fifo_ptr
  import rram_ctrl_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push_req,
  input  logic                     pop_req,
  output logic                     push_ok,
  output logic                     pop_ok,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_CNT  = (AW+1)'(AF_LEVEL);

  logic [AW:0] wr_ptr, rd_ptr;

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign almost_full = (count >= AF_CNT);
  assign wr_addr     = wr_ptr[AW-1:0];
  assign rd_addr     = rd_ptr[AW-1:0];

  // A full FIFO is never empty, so a simultaneous pop always frees the slot.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push_ok) overflow  <= 1'b1;
      if (pop_req && empty)     underflow <= 1'b1;
    end
  end
endmodule

// File: rtl/rram_inst_fifo.sv
// Show-ahead instruction FIFO feeding rram_controller_fsm.
// Optional high-water-mark output enabled by RRAM_INST_FIFO_HWM_EN.
module rram_inst_fifo
  import rram_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH  = rram_ctrl_pkg::INSTR_WIDTH,
  parameter int OPCODE_WIDTH = rram_ctrl_pkg::OPCODE_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AF_LEVEL     = DEPTH - 2
) (
  input  logic                                CLK,
  input  logic                                reset_n,
  input  logic                                clr,
  input  logic                                push_n,
  input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] din,
  output logic                                full,
  output logic                                almost_full,
  input  logic                                pop_n,
  output logic                                empty,
  output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                overflow,
  output logic                                underflow
`ifdef RRAM_INST_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]              hwm
`endif
);
  localparam int W  = INSTR_WIDTH + OPCODE_WIDTH;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  last_pop;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          push_ok, pop_ok;

  rram_fifo_ptr #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_ptr (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .clr         (clr),
    .push_req    (!push_n && !clr),
    .pop_req     (!pop_n && !clr),
    .push_ok     (push_ok),
    .pop_ok      (pop_ok),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_addr] <= din;
  end

  // Keeps dout stable on the last consumed word once the FIFO drains.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)    last_pop <= '0;
    else if (pop_ok) last_pop <= mem[rd_addr];
  end

  assign dout = empty ? last_pop : mem[rd_addr];

`ifdef RRAM_INST_FIFO_HWM_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)         hwm <= '0;
    else if (clr)         hwm <= '0;
    else if (count > hwm) hwm <= count;
  end
`endif
endmodule

// File: tb/tb_rram_inst_fifo.sv
// Directed bench for rram_inst_fifo: show-ahead timing, flags, wrap, clr and async reset.
module tb_rram_inst_fifo;
  import rram_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        reset_n, clr, push_n, pop_n;
  logic [19:0] din, dout;
  logic        full, almost_full, empty, overflow, underflow;
  logic [4:0]  count;
`ifdef RRAM_INST_FIFO_HWM_EN
  logic [4:0]  hwm;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] q[$];
  logic [19:0] w;

  always #5 CLK = ~CLK;

  rram_inst_fifo dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .clr         (clr),
    .push_n      (push_n),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .pop_n       (pop_n),
    .empty       (empty),
    .dout        (dout),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef RRAM_INST_FIFO_HWM_EN
    ,
    .hwm         (hwm)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; push_n = 1'b1; pop_n = 1'b1; din = '0;
    #3;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
`ifdef RRAM_INST_FIFO_HWM_EN
    chk("rst_hwm", 32'(hwm), 0);
`endif
    #4 reset_n = 1'b1;
    step();

    // single push then pop
    din = 20'h4_0000; push_n = 1'b0;
    step();
    push_n = 1'b1;
    chk("p1_empty", 32'(empty), 0);
    chk("p1_dout", 32'(dout), 32'h4_0000);
    chk("p1_count", 32'(count), 1);
    chk("p1_opcode", 32'(opcode_of(dout)), 32'(STORE));
    pop_n = 1'b0;
    step();
    pop_n = 1'b1;
    chk("p1_pop_empty", 32'(empty), 1);
    chk("p1_pop_count", 32'(count), 0);
    chk("p1_pop_unf", 32'(underflow), 0);
    chk("p1_hold_dout", 32'(dout), 32'h4_0000);

    // back-to-back burst
    q = '{20'h4_440A, 20'h4_C6FF, 20'h5_0000};
    foreach (q[i]) begin
      din = q[i]; push_n = 1'b0;
      step();
    end
    push_n = 1'b1;
    chk("b3_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b3_dout%0d", i), 32'(dout), 32'(q[i]));
      pop_n = 1'b0;
      step();
    end
    pop_n = 1'b1;
    chk("b3_empty", 32'(empty), 1);
    q.delete();

    // fill to full, overflow, drain
    for (int i = 0; i < 16; i++) begin
      din = 20'hA_0000 + 20'(i); push_n = 1'b0;
      q.push_back(din);
      step();
      if (i == 12 || i == 13)
        chk($sformatf("fill_af%0d", i + 1), 32'(almost_full), (i == 13) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    din = 20'hF_FFFF;
    step();
    push_n = 1'b1;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_full", 32'(full), 1);
`ifdef RRAM_INST_FIFO_HWM_EN
    chk("fill_hwm", 32'(hwm), 16);
`endif
    for (int i = 0; i < 16; i++) begin
      w = q.pop_front();
      chk($sformatf("drain%0d", i), 32'(dout), 32'(w));
      pop_n = 1'b0;
      step();
    end
    pop_n = 1'b1;
    chk("drain_empty", 32'(empty), 1);

    // refill, then push+pop while full across the pointer wrap
    for (int i = 0; i < 16; i++) begin
      din = 20'hB_0000 + 20'(i); push_n = 1'b0;
      q.push_back(din);
      step();
    end
    for (int j = 0; j < 40; j++) begin
      chk($sformatf("wrap_head%0d", j), 32'(dout), 32'(q[0]));
      din = 20'hC_0000 + 20'(j); push_n = 1'b0; pop_n = 1'b0;
      step();
      void'(q.pop_front());
      q.push_back(din);
      chk($sformatf("wrap_cnt%0d", j), 32'(count), 16);
    end
    push_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = q.pop_front();
      chk($sformatf("wrap_drain%0d", i), 32'(dout), 32'(w));
      step();
    end
    pop_n = 1'b1;
    chk("wrap_empty", 32'(empty), 1);

    // push+pop on empty, then clr
    din = 20'h6_0001; push_n = 1'b0; pop_n = 1'b0;
    step();
    push_n = 1'b1; pop_n = 1'b1;
    chk("pe_count", 32'(count), 1);
    chk("pe_unf", 32'(underflow), 1);
    chk("pe_dout", 32'(dout), 32'h6_0001);
    clr = 1'b1; push_n = 1'b0; din = 20'h7_0000;
    step();
    clr = 1'b0; push_n = 1'b1;
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_ovf", 32'(overflow), 0);
`ifdef RRAM_INST_FIFO_HWM_EN
    step();
    chk("clr_hwm", 32'(hwm), 0);
`endif

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      din = 20'h5_1000 + 20'(i); push_n = 1'b0;
      step();
    end
    chk("mid_count", 32'(count), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_dout", 32'(dout), 0);
`ifdef RRAM_INST_FIFO_HWM_EN
    chk("arst_hwm", 32'(hwm), 0);
`endif
    push_n = 1'b1;
    #10 reset_n = 1'b1;
    step();
    chk("post_rst_count", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rram_inst_fifo.md
Name: rram_inst_fifo

Overview:
- Instruction FIFO directly upstream of rram_controller_fsm; buffers host instruction words and presents them to the controller.
- First-word-fall-through (show-ahead): head word sits on dout whenever empty=0, so the controller samples dout and pops in the same cycle.
- Active-low push/pop strobes match the controller's pop_n_instFIFO / empty_instFIFO / dout_instFIFO interface.

Parameters:
- INSTR_WIDTH, 4, opcode field width.
- OPCODE_WIDTH, 16, operand field width (row/col/burst).
- DEPTH, 16, number of entries; power of two, minimum 4.
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts.

Ports:
- CLK  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active-high.
- push_n  in  1  host write strobe, active-low.
- din  in  INSTR_WIDTH+OPCODE_WIDTH  instruction word from host.
- full  out  1  no free entry.
- almost_full  out  1  count >= AF_LEVEL.
- pop_n  in  1  controller read strobe, active-low (driven by pop_n_instFIFO).
- empty  out  1  no valid word (to empty_instFIFO).
- dout  out  INSTR_WIDTH+OPCODE_WIDTH  head word, valid when empty=0 (to dout_instFIFO).
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH-entry register array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB differs on wrap.
- full = (ptr MSBs differ) && (lower bits equal). empty = (count == 0).
- Reset (async, reset_n=0): pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
- push accepted when push_n=0 && (full=0 || pop accepted in the same cycle).
- Accepted push writes din at wr_ptr and increments wr_ptr.
- Push while full with no pop: word dropped, overflow<=1.
- pop accepted when pop_n=0 && empty=0. Accepted pop increments rd_ptr.
- Pop while empty: ignored, underflow<=1.
- Push+pop in the same cycle:
  - Non-empty (including full): both accepted, count unchanged.
  - Empty: push accepted, pop rejected, underflow<=1.
- Latency:
  - Push at edge k into an empty FIFO: empty falls after edge k, and dout = that word in the same cycle (combinational read of array[rd_ptr]).
  - Pop at edge k: dout shows the next entry after edge k.
- While empty=1: dout holds the last popped word (0 after reset). dout must not change while empty=0 and no pop is accepted.
- count, full, almost_full, empty: all derived from registered pointers only, with no combinational path from push_n/pop_n.
- Pointer wrap: modulo 2*DEPTH, natural rollover.
- clr=1: next edge sets pointers=0, count=0, empty=1, overflow=0, underflow=0. clr overrides any push/pop in that cycle. Array contents are not cleared.
- reset_n asserted mid-operation: immediate async clear of all state above; in-flight push is lost.

Optional Feature:
- Macro RRAM_INST_FIFO_HWM_EN.
- Defined: adds output port hwm, width $clog2(DEPTH)+1, holding the high-water mark of count (max count since reset/clr). Updates one cycle after count; cleared by reset_n and clr.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rram_ctrl_pkg:
  - INSTR_WIDTH/OPCODE_WIDTH defaults.
  - typedef inst_word_t (logic [INSTR_WIDTH+OPCODE_WIDTH-1:0]).
  - opcode localparams (STORE=4'h4, READ=4'h5, HAM_WEIGHT=4'h6, HAM_SEG=4'h7) for benches/debug decode.
- One sub-module: rram_fifo_ptr (pointer, count and flag logic, parameterised by DEPTH). The storage array stays in the top.

Test Plan:
- Reset then push 20'h4_0000 once: empty falls after that edge, dout=20'h4_0000 the same cycle, count=1. pop_n=0 one cycle: empty=1, count=0, underflow=0.
- Push 20'h4_440A, 20'h4_C6FF, 20'h5_0000 back-to-back, then pop three: dout sequence 4_440A, 4_C6FF, 5_0000, one word per pop, no bubbles.
- Fill DEPTH=16 entries: full=1, count=16, almost_full from count=14. One more push: dropped, overflow=1. Pop 16: original order returned.
- Full FIFO with push+pop in the same cycle: count stays 16, new word becomes last, head advances. Repeat 40 cycles to cross the pointer wrap: data order preserved.
- Empty FIFO with pop_n=0 and push_n=0 together: word stored, count=1, underflow=1. Then clr=1 one cycle: count=0, empty=1, underflow=0.
- Assert reset_n=0 mid-burst between clock edges: empty=1 and count=0 immediately, before the next edge. With RRAM_INST_FIFO_HWM_EN: hwm=0 after reset, and hwm=16 after the fill test.
